// File: rtl/eq_ctrl_pkg.sv
// Shared equalizer control constants: band count, gain width, reset gain and
// the gain-scheduler FSM state encoding.
package eq_ctrl_pkg;

    localparam int unsigned NUM_BANDS        = 8;
    localparam int unsigned GAIN_W           = 2;
    localparam int unsigned DEFAULT_GAIN_VAL = 1;
    localparam int unsigned RAMP_DIV_DEFAULT = 1;

    localparam int unsigned STATE_W = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_RAMP   = 2'd3;

endpackage

// File: rtl/gain_stepper.sv
// Per-band next active gain. With EQ_GAIN_RAMP_EN defined the active gain
// moves one LSB toward its target and stops there; otherwise it jumps
// straight to the target.
module gain_stepper #(
    parameter int unsigned GAIN_BITS = 2
) (
    input  logic [GAIN_BITS-1:0] active_i,
    input  logic [GAIN_BITS-1:0] target_i,
    output logic [GAIN_BITS-1:0] next_gain_c
);

`ifdef EQ_GAIN_RAMP_EN
    // Single-LSB step toward the target; equal values hold, so no overshoot.
    always_comb begin
        next_gain_c = active_i;
        if (active_i < target_i) begin
            next_gain_c = active_i + GAIN_BITS'(1);
        end else if (active_i > target_i) begin
            next_gain_c = active_i - GAIN_BITS'(1);
        end
    end
`else
    // Direct copy of the target.
    always_comb begin
        next_gain_c = target_i;
        if (active_i == target_i) begin
            next_gain_c = active_i;
        end
    end
`endif

endmodule

// File: rtl/eq_gain_scheduler.sv
// Equalizer band-gain scheduler. Buffers host gain writes as targets and
// commits them to the amplifier only on frame boundaries (clk_enable &&
// phase_min), so gains never change mid-convolution.
// Build option: EQ_GAIN_RAMP_EN enables one-LSB-per-commit ramping with a
// RAMP_DIV boundary divider between steps.
module eq_gain_scheduler
    import eq_ctrl_pkg::*;
#(
    parameter int unsigned NUMBER_OF_FILTERS = NUM_BANDS,
    parameter int unsigned GAIN_BITS         = GAIN_W,
    parameter int unsigned BAND_IDX_BITS     = $clog2(NUMBER_OF_FILTERS),
    parameter int unsigned DEFAULT_GAIN      = DEFAULT_GAIN_VAL,
    parameter int unsigned RAMP_DIV          = RAMP_DIV_DEFAULT
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clk_enable,
    input  logic                                   phase_min,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic                                   cfg_all,
    input  logic [BAND_IDX_BITS-1:0]               cfg_band,
    input  logic [GAIN_BITS-1:0]                   cfg_gain,
    output logic                                   cfg_err,
    output logic                                   amplifier_enable,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
    output logic                                   busy,
    output logic                                   update_pulse
);

    if (RAMP_DIV < 1) begin : g_bad_ramp_div
        $error("eq_gain_scheduler: RAMP_DIV must be >= 1");
    end

    logic [STATE_W-1:0]   state_q, state_d;
    logic [GAIN_BITS-1:0] target_q [NUMBER_OF_FILTERS];
    logic [GAIN_BITS-1:0] target_d [NUMBER_OF_FILTERS];
    logic [GAIN_BITS-1:0] active_q [NUMBER_OF_FILTERS];
    logic [GAIN_BITS-1:0] active_d [NUMBER_OF_FILTERS];
    logic [GAIN_BITS-1:0] step_c   [NUMBER_OF_FILTERS];
    logic                 cfg_ready_q, busy_q;
    logic                 amp_en_q, amp_en_d;
    logic                 pulse_q, pulse_d;
    logic                 err_q, err_d;
    logic                 accept_c, boundary_c, band_ok_c, changed_c;

`ifdef EQ_GAIN_RAMP_EN
    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    logic [DIV_W-1:0] div_q, div_d;
    logic             settled_c;
`endif

    assign accept_c   = cfg_valid && cfg_ready_q;
    assign boundary_c = clk_enable && phase_min;
    assign band_ok_c  = 32'(cfg_band) < NUMBER_OF_FILTERS;

    // Per-band step units and output packing.
    for (genvar g = 0; g < NUMBER_OF_FILTERS; g++) begin : g_band
        gain_stepper #(
            .GAIN_BITS (GAIN_BITS)
        ) u_stepper (
            .active_i    (active_q[g]),
            .target_i    (target_q[g]),
            .next_gain_c (step_c[g])
        );
        assign amplifier_gains[g*GAIN_BITS +: GAIN_BITS] = active_q[g];
    end

    // Does the pending commit change any active gain.
    always_comb begin
        changed_c = 1'b0;
        for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
            if (step_c[i] != active_q[i]) changed_c = 1'b1;
        end
    end

`ifdef EQ_GAIN_RAMP_EN
    // Will every band sit on its target once this commit lands.
    always_comb begin
        settled_c = 1'b1;
        for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
            if (step_c[i] != target_q[i]) settled_c = 1'b0;
        end
    end
`endif

    // Next-state: target writes, FSM transitions, commit and status pulses.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        active_d = active_q;
        amp_en_d = amp_en_q;
        pulse_d  = 1'b0;
        err_d    = 1'b0;
`ifdef EQ_GAIN_RAMP_EN
        div_d    = div_q;
`endif

        if (accept_c) begin
            if (cfg_all) begin
                for (int i = 0; i < NUMBER_OF_FILTERS; i++) target_d[i] = cfg_gain;
            end else if (band_ok_c) begin
                target_d[cfg_band] = cfg_gain;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (boundary_c) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                active_d = step_c;
                amp_en_d = 1'b1;
                pulse_d  = changed_c;
`ifdef EQ_GAIN_RAMP_EN
                div_d    = '0;
                state_d  = settled_c ? ST_IDLE : ST_RAMP;
`else
                state_d  = ST_IDLE;
`endif
            end
            ST_RAMP: begin
`ifdef EQ_GAIN_RAMP_EN
                if (boundary_c) begin
                    if (div_q == DIV_W'(RAMP_DIV - 1)) begin
                        div_d   = '0;
                        state_d = ST_COMMIT;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            amp_en_q    <= 1'b0;
            pulse_q     <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
                target_q[i] <= GAIN_BITS'(DEFAULT_GAIN);
                active_q[i] <= GAIN_BITS'(DEFAULT_GAIN);
            end
`ifdef EQ_GAIN_RAMP_EN
            div_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= (state_d != ST_COMMIT);
            busy_q      <= (state_d != ST_IDLE);
            amp_en_q    <= amp_en_d;
            pulse_q     <= pulse_d;
            err_q       <= err_d;
            target_q    <= target_d;
            active_q    <= active_d;
`ifdef EQ_GAIN_RAMP_EN
            div_q       <= div_d;
`endif
        end
    end

    assign cfg_ready        = cfg_ready_q;
    assign busy             = busy_q;
    assign amplifier_enable = amp_en_q;
    assign update_pulse     = pulse_q;
    assign cfg_err          = err_q;

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Self-checking bench for eq_gain_scheduler: directed scenarios followed by
// random traffic, all checked against a transaction-level reference model.
module tb_eq_gain_scheduler;

    localparam int unsigned NB = 8;
    localparam int unsigned GB = 2;
    localparam int unsigned RD = 2;

    logic              clk;
    logic              rst;
    logic              clk_enable;
    logic              phase_min;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_all;
    logic [2:0]        cfg_band;
    logic [GB-1:0]     cfg_gain;
    logic              cfg_err;
    logic              amplifier_enable;
    logic [NB*GB-1:0]  amplifier_gains;
    logic              busy;
    logic              update_pulse;

    int checks = 0;
    int errors = 0;

    eq_gain_scheduler #(
        .RAMP_DIV (RD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .clk_enable       (clk_enable),
        .phase_min        (phase_min),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_all          (cfg_all),
        .cfg_band         (cfg_band),
        .cfg_gain         (cfg_gain),
        .cfg_err          (cfg_err),
        .amplifier_enable (amplifier_enable),
        .amplifier_gains  (amplifier_gains),
        .busy             (busy),
        .update_pulse     (update_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: targets, active gains and the pending-work flags.
    int mt [NB];
    int ma [NB];
    bit m_pending;   // write waiting for a boundary
    bit m_commit;    // commit happens at the next edge
    bit m_ramping;   // active still short of target, waiting for boundaries
    int m_div;
    bit m_en, m_pulse, m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t got %h exp %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [NB*GB-1:0] model_gains();
        logic [NB*GB-1:0] v;
        v = '0;
        for (int i = 0; i < NB; i++) v[i*GB +: GB] = GB'(ma[i]);
        return v;
    endfunction

    task automatic model_step(input bit r, input bit ce, input bit pm, input bit v,
                              input bit all, input int band, input int gain);
        bit acc, b, changed, far;
        int nt [NB];
        int na;
        if (r) begin
            for (int i = 0; i < NB; i++) begin mt[i] = 1; ma[i] = 1; end
            m_pending = 0; m_commit = 0; m_ramping = 0; m_div = 0;
            m_en = 0; m_pulse = 0; m_err = 0;
            return;
        end
        acc = v && !m_commit;
        b   = ce && pm;
        m_pulse = 0;
        m_err   = 0;
        nt = mt;
        if (acc) begin
            if (all) begin
                for (int i = 0; i < NB; i++) nt[i] = gain;
            end else if (band < NB) begin
                nt[band] = gain;
            end else begin
                m_err = 1;
            end
        end
        if (m_commit) begin
            changed = 0;
            far = 0;
            for (int i = 0; i < NB; i++) begin
`ifdef EQ_GAIN_RAMP_EN
                na = (ma[i] < mt[i]) ? ma[i] + 1 : (ma[i] > mt[i]) ? ma[i] - 1 : ma[i];
`else
                na = mt[i];
`endif
                if (na != ma[i]) changed = 1;
                ma[i] = na;
                if (ma[i] != mt[i]) far = 1;
            end
            m_pulse  = changed;
            m_en     = 1;
            m_commit = 0;
            if (far) begin m_ramping = 1; m_div = 0; end
        end else if (m_pending) begin
            if (b) begin m_commit = 1; m_pending = 0; end
        end else if (m_ramping) begin
            if (b) begin
                if (m_div == RD - 1) begin m_commit = 1; m_ramping = 0; m_div = 0; end
                else m_div++;
            end
        end else if (acc) begin
            m_pending = 1;
        end
        mt = nt;
    endtask

    task automatic check_all();
        check_eq("cfg_ready", 32'(cfg_ready), 32'(!m_commit));
        check_eq("busy", 32'(busy), 32'(m_pending || m_commit || m_ramping));
        check_eq("gains", 32'(amplifier_gains), 32'(model_gains()));
        check_eq("amp_enable", 32'(amplifier_enable), 32'(m_en));
        check_eq("update_pulse", 32'(update_pulse), 32'(m_pulse));
        check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic cyc(input bit r, input bit ce, input bit pm, input bit v,
                       input bit all, input int band, input int gain);
        rst        = r;
        clk_enable = ce;
        phase_min  = pm;
        cfg_valid  = v;
        cfg_all    = all;
        cfg_band   = 3'(band);
        cfg_gain   = GB'(gain);
        model_step(r, ce, pm, v, all, band, gain);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // T1 reset
        cyc(1, 1, 0, 0, 0, 0, 0);
        check_eq("t1_gains", 32'(amplifier_gains), 32'h5555);
        check_eq("t1_enable", 32'(amplifier_enable), 32'h0);
        check_eq("t1_busy", 32'(busy), 32'h0);
        check_eq("t1_ready", 32'(cfg_ready), 32'h1);

        // T2 single write, boundary much later
        cyc(0, 1, 0, 1, 0, 3, 2);
        idle(10);
        check_eq("t2_hold", 32'(amplifier_gains), 32'h5555);
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check_eq("t2_gains", 32'(amplifier_gains), 32'h5595);
        check_eq("t2_pulse", 32'(update_pulse), 32'h1);
        check_eq("t2_enable", 32'(amplifier_enable), 32'h1);
        idle(1);
        check_eq("t2_busy", 32'(busy), 32'h0);

        // T3 broadcast 0 then 3, boundaries every other cycle
        cyc(0, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin cyc(0, 1, 1, 0, 0, 0, 0); idle(1); end
        check_eq("t3_zero", 32'(amplifier_gains), 32'h0000);
        cyc(0, 1, 0, 1, 1, 0, 3);
        for (int i = 0; i < 12; i++) begin cyc(0, 1, 1, 0, 0, 0, 0); idle(1); end
        check_eq("t3_full", 32'(amplifier_gains), 32'hFFFF);

        // T4 write coincident with boundary, then a write during COMMIT
        cyc(0, 1, 0, 1, 0, 0, 2);
        cyc(0, 1, 1, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 1, 0);
`ifdef EQ_GAIN_RAMP_EN
        check_eq("t4_gains", 32'(amplifier_gains), 32'hFFFE);
`else
        check_eq("t4_gains", 32'(amplifier_gains), 32'hFFFC);
`endif
        cyc(0, 1, 0, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin cyc(0, 1, 1, 0, 0, 0, 0); idle(1); end
        check_eq("t4_final", 32'(amplifier_gains), 32'hFFF0);

        // T5 boundaries suppressed by clk_enable
        cyc(0, 1, 0, 1, 0, 2, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        check_eq("t5_hold", 32'(amplifier_gains), 32'hFFF0);
        check_eq("t5_busy", 32'(busy), 32'h1);
        cyc(0, 1, 1, 0, 0, 0, 0);
        idle(2);
        check_eq("t5_commit_pulse_gone", 32'(update_pulse), 32'h0);

        // T6 reset in the middle of a change
        cyc(0, 1, 0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        idle(1);
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check_eq("t6_gains", 32'(amplifier_gains), 32'h5555);
        check_eq("t6_enable", 32'(amplifier_enable), 32'h0);
        for (int i = 0; i < 4; i++) begin cyc(0, 1, 1, 0, 0, 0, 0); idle(1); end
        check_eq("t6_quiet", 32'(amplifier_gains), 32'h5555);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 9) != 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0,
                int'($urandom_range(0, NB - 1)),
                int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
